// File: rtl/icap_bitstream_loader.sv
// Streams a counted partial bitstream from a valid/ready source through a small word FIFO
// into the ICAP write port, reporting done/error to the reconfiguration controller.
module icap_bitstream_loader #(
  parameter int TECH         = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int BIT_SWAP     = 1,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] bs_words,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic        icap_avail,
  input  logic        icap_prdone,
  input  logic        icap_prerror,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_sent
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam bit IS_E2 = (TECH == 1);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_DONE, FLUSH} state_t;

  state_t      state;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] rx_left, tx_left, rx_next;
  logic [31:0] timer;
  logic [31:0] rd_word;
  logic        fifo_empty, fifo_full;
  logic        accept, push, issue, fail_in_write;

  function automatic logic [31:0] swap_bits(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (BIT_SWAP == 1) begin
      for (int k = 0; k < 4; k++) begin
        for (int b = 0; b < 8; b++) begin
          r[8*k+b] = w[8*k+7-b];
        end
      end
    end
    return r;
  endfunction

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_word    = mem[rd_ptr[AW-1:0]];

  always_comb begin
    // NOTE: assign a default before the case so every path drives s_ready and no latch is inferred.
    s_ready = 1'b0;
    case (state)
      WRITE:   s_ready = (rx_left != '0) && !fifo_full;
      FLUSH:   s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  assign accept        = s_valid && s_ready;
  assign push          = accept && (state == WRITE);
  assign fail_in_write = abort || (!IS_E2 && icap_prerror);
  assign issue         = (state == WRITE) && !fifo_empty && (IS_E2 || icap_avail) && !fail_in_write;
  assign rx_next       = (accept && rx_left != '0) ? rx_left - 32'd1 : rx_left;
  assign busy          = (state != IDLE);

  // NOTE: the storage array carries no reset; only the pointers define FIFO contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_left    <= '0;
      tx_left    <= '0;
      timer      <= '0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      words_sent <= '0;
    end else begin
      done       <= 1'b0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      rx_left    <= rx_next;
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            rx_left    <= bs_words;
            tx_left    <= bs_words;
            error      <= 1'b0;
            words_sent <= '0;
            if (bs_words == '0) done  <= 1'b1;
            else                state <= WRITE;
          end
        end

        WRITE: begin
          if (fail_in_write) begin
            // A word accepted in this same cycle still counts against rx_left.
            error  <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= (rx_next != '0) ? FLUSH : IDLE;
          end else if (issue) begin
            icap_csib  <= 1'b0;
            icap_rdwrb <= 1'b0;
            icap_i     <= swap_bits(rd_word);
            words_sent <= words_sent + 32'd1;
            tx_left    <= tx_left - 32'd1;
            if (tx_left == 32'd1) begin
              if (IS_E2) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                timer <= '0;
                state <= WAIT_DONE;
              end
            end
          end
        end

        WAIT_DONE: begin
          if (icap_prerror || abort || timer == 32'(DONE_TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= IDLE;
          end else if (icap_prdone) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        FLUSH: begin
          if (abort || rx_next == '0) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icap_bitstream_loader.sv
// Bench for icap_bitstream_loader: scoreboard of upstream words vs ICAP writes, plus directed
// checks of completion, timeout, error/abort flushing, zero-length loads, TECH=1 and reset.
module tb_icap_bitstream_loader;

  localparam int DEPTH = 16;
  localparam int TO    = 50;

  logic        clk, rst, start, abort;
  logic [31:0] bs_words, s_data, icap_i, words_sent;
  logic        s_valid, s_ready, icap_csib, icap_rdwrb, icap_avail, icap_prdone, icap_prerror;
  logic        busy, done, error;

  logic        start1, s_valid1, s_ready1, icap_csib1, icap_rdwrb1, busy1, done1, error1;
  logic [31:0] bs_words1, s_data1, icap_i1, words_sent1;

  icap_bitstream_loader #(.TECH(2), .FIFO_DEPTH(DEPTH), .BIT_SWAP(1), .DONE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bs_words(bs_words),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i),
    .icap_avail(icap_avail), .icap_prdone(icap_prdone), .icap_prerror(icap_prerror),
    .busy(busy), .done(done), .error(error), .words_sent(words_sent)
  );

  // Seven-series flavour: avail low and prerror high must both be ignored.
  icap_bitstream_loader #(.TECH(1), .FIFO_DEPTH(4), .BIT_SWAP(1), .DONE_TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .bs_words(bs_words1),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .icap_csib(icap_csib1), .icap_rdwrb(icap_rdwrb1), .icap_i(icap_i1),
    .icap_avail(1'b0), .icap_prdone(1'b0), .icap_prerror(1'b1),
    .busy(busy1), .done(done1), .error(error1), .words_sent(words_sent1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference byte-wise bit reversal, written as an index mapping over the whole word.
  function automatic logic [31:0] ref_swap(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[(i / 8) * 8 + (7 - (i % 8))];
    return r;
  endfunction

  // Scoreboard state
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  int          cyc = 0;
  int          seen = 0;
  int          acc = 0;
  bit          expect_quiet = 1'b0;
  bit          chk_full = 1'b0;
  bit          saw_full = 1'b0;
  bit          prev_avail = 1'b0;
  logic [31:0] first_i = '0;
  logic [31:0] sc_w;
  int          sc_c;
  logic [31:0] stim [64];

  always @(posedge clk) begin
    prev_avail = icap_avail;
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (expect_quiet) begin
        check("csib_after_stop", 32'(icap_csib), 32'd1);
      end else if (!icap_csib) begin
        check("rdwrb_on_write", 32'(icap_rdwrb), 32'd0);
        check("avail_before_issue", 32'(prev_avail), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got 0x%08h, expected no write", icap_i);
        end else begin
          sc_w = exp_q.pop_front();
          sc_c = cyc_q.pop_front();
          check("icap_i_order", icap_i, ref_swap(sc_w));
          check("latency_ge2", 32'(cyc - sc_c >= 2), 32'd1);
          if (seen == 0) first_i = icap_i;
          seen++;
          check("words_sent_track", words_sent, 32'(seen));
        end
      end else begin
        check("rdwrb_idle", 32'(icap_rdwrb), 32'd1);
      end
      if (chk_full && s_valid && !s_ready) begin
        check("full_occupancy", 32'(acc - seen), 32'(DEPTH));
        saw_full = 1'b1;
      end
      if (s_valid && s_ready) begin
        if (!expect_quiet) begin
          exp_q.push_back(s_data);
          cyc_q.push_back(cyc);
        end
        acc++;
      end
    end
  end

  task automatic fill_stim(input logic [31:0] base);
    for (int i = 0; i < 64; i++) stim[i] = base + 32'(i) * 32'h0102_0304;
  endtask

  // Call at posedge+1; presents stim[first..first+n-1] and waits for each handshake.
  task automatic send_list(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      s_valid = 1'b1;
      s_data  = stim[first + i];
      do begin
        @(negedge clk);
        waited++;
      end while (!s_ready && waited < 200);
      if (!s_ready) begin
        n_checks++;
        $display("FAIL upstream_stall: word %0d not accepted, expected acceptance", first + i);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_seen(input int n, input int budget);
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (seen < n) begin
      n_checks++;
      $display("FAIL wait_seen: got %0d words, expected %0d", seen, n);
    end
  endtask

  task automatic do_start(input logic [31:0] n);
    @(posedge clk); #1;
    exp_q.delete();
    cyc_q.delete();
    seen = 0; acc = 0;
    expect_quiet = 1'b0; chk_full = 1'b0; saw_full = 1'b0;
    start = 1'b1; bs_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_prdone();
    @(posedge clk); #1 icap_prdone = 1'b1;
    @(posedge clk); #1 icap_prdone = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("error_after_done", 32'(error), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_csib"}, 32'(icap_csib), 32'd1);
    check({tag, "_rdwrb"}, 32'(icap_rdwrb), 32'd1);
    check({tag, "_icap_i"}, icap_i, 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words_sent"}, words_sent, 32'd0);
  endtask

  task automatic wait_ready1();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_ready1 && k < 50);
    check("t1_ready", 32'(s_ready1), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; bs_words = '0;
    s_valid = 1'b0; s_data = '0; icap_avail = 1'b1; icap_prdone = 1'b0; icap_prerror = 1'b0;
    start1 = 1'b0; bs_words1 = '0; s_valid1 = 1'b0; s_data1 = '0;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Four-word load with sync word; ICAPE3 flavour completes on prdone.
    stim[0] = 32'hAA99_5566; stim[1] = 32'h2000_0000;
    stim[2] = 32'h3000_8001; stim[3] = 32'h0000_000D;
    do_start(4);
    send_list(0, 4);
    wait_seen(4, 100);
    check("sync_word_swapped", first_i, 32'h5599_AA66);
    @(negedge clk);
    check("wait_done_busy", 32'(busy), 32'd1);
    check("last_word_held", icap_i, 32'h0000_00B0);
    check("csib_high_waiting", 32'(icap_csib), 32'd1);
    pulse_prdone();
    check("four_words_sent", words_sent, 32'd4);

    // 40-word burst with avail stalled long enough to fill the FIFO.
    fill_stim(32'hC0DE_0000);
    do_start(40);
    chk_full = 1'b1;
    fork
      send_list(0, 40);
      begin
        wait_seen(10, 200);
        @(posedge clk); #1 icap_avail = 1'b0;
        repeat (20) @(posedge clk);
        #1 icap_avail = 1'b1;
      end
    join
    wait_seen(40, 300);
    chk_full = 1'b0;
    check("burst_saw_full", 32'(saw_full), 32'd1);
    check("burst_words_sent", words_sent, 32'd40);
    check("burst_queue_empty", 32'(exp_q.size()), 32'd0);
    pulse_prdone();

    // prerror after the fifth of twenty words: remaining words drained upstream.
    fill_stim(32'h5EED_0000);
    do_start(20);
    fork
      send_list(0, 20);
      begin
        wait_seen(5, 200);
        icap_prerror = 1'b1;
        @(posedge clk); #1 icap_prerror = 1'b0;
        expect_quiet = 1'b1;
      end
    join
    @(negedge clk);
    check("prerror_busy", 32'(busy), 32'd0);
    check("prerror_error", 32'(error), 32'd1);
    check("prerror_words_sent", words_sent, 32'd5);

    // Abort after three of eight: exactly five words consumed in FLUSH.
    fill_stim(32'hAB0B_0000);
    do_start(8);
    check("error_cleared_on_start", 32'(error), 32'd0);
    send_list(0, 3);
    wait_seen(3, 100);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    expect_quiet = 1'b1;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_error", 32'(error), 32'd1);
    check("flush_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    send_list(3, 4);
    @(negedge clk);
    check("flush_not_done_after4", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send_list(7, 1);
    @(negedge clk);
    check("flush_idle", 32'(busy), 32'd0);
    check("abort_words_sent", words_sent, 32'd3);

    // Zero-length load.
    @(posedge clk); #1 start = 1'b1; bs_words = 32'd0;
    @(posedge clk); #1 start = 1'b0;
    expect_quiet = 1'b1;
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_error_cleared", 32'(error), 32'd0);
    @(negedge clk);
    check("zero_done_one_cycle", 32'(done), 32'd0);

    // No prdone after the last word: error exactly TO cycles later.
    fill_stim(32'h7100_0000);
    do_start(2);
    send_list(0, 2);
    wait_seen(2, 100);
    k = 0;
    while (!error && k < TO + 20) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", 32'(k), 32'(TO));
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);

    // TECH=1 instance: two words, done without prdone, avail/prerror ignored.
    @(posedge clk); #1 start1 = 1'b1; bs_words1 = 32'd2;
    @(posedge clk); #1 start1 = 1'b0;
    s_valid1 = 1'b1; s_data1 = 32'h3000_8001;
    wait_ready1();
    @(posedge clk); #1 s_data1 = 32'h0000_000D;
    wait_ready1();
    @(posedge clk); #1 s_valid1 = 1'b0;
    k = 0;
    while (!done1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t1_done", 32'(done1), 32'd1);
    check("t1_last_word", icap_i1, 32'h0000_00B0);
    check("t1_csib_low", 32'(icap_csib1), 32'd0);
    check("t1_words_sent", words_sent1, 32'd2);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done1), 32'd0);
    check("t1_idle", 32'(busy1), 32'd0);
    check("t1_no_error", 32'(error1), 32'd0);

    // Reset in the middle of a load.
    fill_stim(32'h0BAD_0000);
    do_start(6);
    send_list(0, 3);
    wait_seen(1, 50);
    check("mid_load_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1 check_reset("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
